// File: rtl/lookup_type_pipe_if.sv
// Lookup request/response handshake bundle for lookup_type_pipe.
// slave = pipeline side, master = packet parser / key-extraction side.
interface lookup_type_pipe_if #(
  parameter int TYPE_NUM         = 4,
  parameter int TYPE_WIDTH       = 8,
  parameter int KEY_FIELD_NUM    = 8,
  parameter int KEY_OFFSET_WIDTH = 6,
  parameter int RULE_NUM         = 8,
  parameter int RULE_AW          = $clog2(RULE_NUM),
  parameter int META_WIDTH       = 16
) ();
  logic i_valid;
  logic o_ready;
  logic [TYPE_NUM-1:0][TYPE_WIDTH-1:0] i_type;
  logic [META_WIDTH-1:0] i_meta;
  logic o_valid;
  logic i_ready;
  logic o_hit;
  logic [RULE_AW-1:0] o_rule_idx;
  logic [KEY_FIELD_NUM-1:0][KEY_OFFSET_WIDTH-1:0] o_result;
  logic [META_WIDTH-1:0] o_meta;

  modport slave (
    input  i_valid, i_type, i_meta, i_ready,
    output o_ready, o_valid, o_hit, o_rule_idx, o_result, o_meta
  );

  modport master (
    output i_valid, i_type, i_meta, i_ready,
    input  o_ready, o_valid, o_hit, o_rule_idx, o_result, o_meta
  );
endinterface

// File: rtl/lookup_type_pipe.sv
// Two-stage masked type lookup: lowest-index hitting rule wins.
// Rule writes, rule/counter read-back and saturating hit counters.
module lookup_type_pipe #(
  parameter int TYPE_NUM         = 4,
  parameter int TYPE_WIDTH       = 8,
  parameter int KEY_FIELD_NUM    = 8,
  parameter int KEY_OFFSET_WIDTH = 6,
  parameter int RULE_NUM         = 8,
  parameter int RULE_AW          = $clog2(RULE_NUM),
  parameter int META_WIDTH       = 16,
  parameter int CNT_WIDTH        = 32,
  parameter bit CLR_ON_READ      = 1'b1,
  parameter int RULE_WIDTH       = 1 + 2*TYPE_NUM*TYPE_WIDTH
                                   + KEY_FIELD_NUM*KEY_OFFSET_WIDTH
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  lookup_type_pipe_if.slave     lk,
  input  logic                  i_rule_wren,
  input  logic [RULE_AW-1:0]    i_rule_waddr,
  input  logic [RULE_WIDTH-1:0] i_rule_wdata,
  input  logic                  i_rd_en,
  input  logic [RULE_AW-1:0]    i_rd_addr,
  input  logic                  i_rd_sel,
  output logic                  o_rd_valid,
  output logic [RULE_WIDTH-1:0] o_rd_data
);

  localparam int TW = TYPE_NUM * TYPE_WIDTH;
  localparam int RW = KEY_FIELD_NUM * KEY_OFFSET_WIDTH;
  localparam int BW = RULE_WIDTH - 1;

  logic [RULE_NUM-1:0]  r_vld;
  logic [BW-1:0]        r_body [RULE_NUM];
  logic [CNT_WIDTH-1:0] r_cnt  [RULE_NUM];

  logic [TW-1:0]       key;
  logic [RULE_NUM-1:0] hit_vec;
  logic                m_hit;
  logic [RULE_AW-1:0]  m_idx;
  logic [RW-1:0]       m_res;
  logic [RULE_NUM-1:0] inc_vec;

  logic                  s1_v;
  logic                  s1_hit;
  logic [RULE_AW-1:0]    s1_idx;
  logic [RW-1:0]         s1_res;
  logic [META_WIDTH-1:0] s1_meta;
  logic                  s2_v;
  logic                  s2_hit;
  logic [RULE_AW-1:0]    s2_idx;
  logic [RW-1:0]         s2_res;
  logic [META_WIDTH-1:0] s2_meta;

  logic s2_free;
  logic acc;
  logic cnt_clr;

  assign key     = lk.i_type;
  assign s2_free = !s2_v || lk.i_ready;
  assign acc     = lk.i_valid && lk.o_ready;
  assign cnt_clr = CLR_ON_READ && i_rd_en && i_rd_sel;

  // S1 is free when empty or draining into S2 this cycle
  assign lk.o_ready = !i_rst && (!s1_v || s2_free);

  assign lk.o_valid    = s2_v;
  assign lk.o_hit      = s2_hit;
  assign lk.o_rule_idx = s2_idx;
  assign lk.o_result   = s2_res;
  assign lk.o_meta     = s2_meta;

  // masked compare of the incoming type against every rule
  always_comb begin
    hit_vec = '0;
    for (int i = 0; i < RULE_NUM; i++) begin
      hit_vec[i] = r_vld[i] &&
        ((key & r_body[i][BW-1 -: TW]) == r_body[i][RW +: TW]);
    end
  end

  // priority select: scanning downward leaves the lowest hit
  always_comb begin
    m_hit = 1'b0;
    m_idx = '0;
    m_res = '0;
    for (int i = RULE_NUM - 1; i >= 0; i--) begin
      if (hit_vec[i]) begin
        m_hit = 1'b1;
        m_idx = RULE_AW'(i);
        m_res = r_body[i][RW-1:0];
      end
    end
  end

  // one-hot increment request for the winning rule
  always_comb begin
    inc_vec = '0;
    if (acc && m_hit) inc_vec[m_idx] = 1'b1;
  end

  // S1: capture lookup result on accept
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      s1_v    <= 1'b0;
      s1_hit  <= 1'b0;
      s1_idx  <= '0;
      s1_res  <= '0;
      s1_meta <= '0;
    end else if (acc) begin
      s1_v    <= 1'b1;
      s1_hit  <= m_hit;
      s1_idx  <= m_idx;
      s1_res  <= m_res;
      s1_meta <= lk.i_meta;
    end else if (s2_free) begin
      s1_v    <= 1'b0;
    end
  end

  // S2: output stage, holds while stalled
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      s2_v    <= 1'b0;
      s2_hit  <= 1'b0;
      s2_idx  <= '0;
      s2_res  <= '0;
      s2_meta <= '0;
    end else if (s2_free) begin
      s2_v    <= s1_v;
      s2_hit  <= s1_hit;
      s2_idx  <= s1_idx;
      s2_res  <= s1_res;
      s2_meta <= s1_meta;
    end
  end

  // rule valid bits: only these need reset
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_vld <= '0;
    end else if (i_rule_wren) begin
      r_vld[i_rule_waddr] <= i_rule_wdata[RULE_WIDTH-1];
    end
  end

  // rule mask/value/result storage
  always_ff @(posedge i_clk) begin
    if (i_rule_wren) r_body[i_rule_waddr] <= i_rule_wdata[BW-1:0];
  end

  // hit counters: write clears, read-clear keeps a coincident hit
  always_ff @(posedge i_clk) begin
    for (int i = 0; i < RULE_NUM; i++) begin
      if (i_rst) begin
        r_cnt[i] <= '0;
      end else if (i_rule_wren && i_rule_waddr == RULE_AW'(i)) begin
        r_cnt[i] <= '0;
      end else if (cnt_clr && i_rd_addr == RULE_AW'(i)) begin
        r_cnt[i] <= CNT_WIDTH'(inc_vec[i]);
      end else if (inc_vec[i] && r_cnt[i] != '1) begin
        r_cnt[i] <= r_cnt[i] + CNT_WIDTH'(1);
      end
    end
  end

  // registered read port returning pre-edge contents
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_rd_valid <= 1'b0;
      o_rd_data  <= '0;
    end else begin
      o_rd_valid <= i_rd_en;
      if (i_rd_en) begin
        o_rd_data <= i_rd_sel ? RULE_WIDTH'(r_cnt[i_rd_addr])
                              : {r_vld[i_rd_addr], r_body[i_rd_addr]};
      end
    end
  end

endmodule

// File: tb/tb_lookup_type_pipe.sv
// Directed bench for lookup_type_pipe (CNT_WIDTH=4 to reach saturation).
// Table-driven lookups plus hand-written multi-cycle sequences.
module tb_lookup_type_pipe;
  localparam int RWD = 113;

  logic clk;
  logic i_rst;
  logic i_rule_wren;
  logic [2:0] i_rule_waddr;
  logic [RWD-1:0] i_rule_wdata;
  logic i_rd_en;
  logic [2:0] i_rd_addr;
  logic i_rd_sel;
  logic o_rd_valid;
  logic [RWD-1:0] o_rd_data;

  int checks = 0;
  int failures = 0;

  localparam logic [47:0] R0 = 48'h1111_1111_1111;
  localparam logic [47:0] R1 = 48'h2222_2222_2222;
  localparam logic [47:0] R3 = 48'h3333_3333_3333;

  lookup_type_pipe_if lk ();

  lookup_type_pipe #(.CNT_WIDTH(4)) dut (
    .i_clk(clk),
    .i_rst(i_rst),
    .lk(lk),
    .i_rule_wren(i_rule_wren),
    .i_rule_waddr(i_rule_waddr),
    .i_rule_wdata(i_rule_wdata),
    .i_rd_en(i_rd_en),
    .i_rd_addr(i_rd_addr),
    .i_rd_sel(i_rd_sel),
    .o_rd_valid(o_rd_valid),
    .o_rd_data(o_rd_data)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic [31:0] typ;
    logic [15:0] meta;
    bit          hit;
    logic [2:0]  idx;
    logic [47:0] res;
  } vec_t;

  vec_t tbl[6];

  function automatic logic [RWD-1:0] mk_rule(input bit v,
      input logic [31:0] m, input logic [31:0] val, input logic [47:0] r);
    return {v, m, val, r};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [127:0] act,
      input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic wr_rule(input logic [2:0] a, input logic [RWD-1:0] d);
    i_rule_wren = 1'b1;
    i_rule_waddr = a;
    i_rule_wdata = d;
    tick();
    i_rule_wren = 1'b0;
  endtask

  task automatic do_read(input logic [2:0] a, input bit sel,
      output logic [RWD-1:0] d);
    i_rd_en = 1'b1;
    i_rd_addr = a;
    i_rd_sel = sel;
    tick();
    i_rd_en = 1'b0;
    chk("rd_valid", 128'(o_rd_valid), 128'(1));
    d = o_rd_data;
  endtask

  task automatic do_lookup(input string nm, input logic [31:0] t,
      input logic [15:0] m, input bit eh, input logic [2:0] ei,
      input logic [47:0] er, input bit wr, input logic [RWD-1:0] wd);
    lk.i_ready = 1'b1;
    lk.i_valid = 1'b1;
    lk.i_type = t;
    lk.i_meta = m;
    i_rule_wren = wr;
    i_rule_waddr = 3'd0;
    i_rule_wdata = wd;
    tick();
    lk.i_valid = 1'b0;
    i_rule_wren = 1'b0;
    chk({nm, "_lat1"}, 128'(lk.o_valid), 128'(0));
    tick();
    chk({nm, "_valid"}, 128'(lk.o_valid), 128'(1));
    chk({nm, "_hit"}, 128'(lk.o_hit), 128'(eh));
    chk({nm, "_idx"}, 128'(lk.o_rule_idx), 128'(ei));
    chk({nm, "_res"}, 128'(lk.o_result), 128'(er));
    chk({nm, "_meta"}, 128'(lk.o_meta), 128'(m));
  endtask

  initial begin
    logic [RWD-1:0] rd;
    int sent;
    int got;
    bit hold;
    logic [15:0] held;
    bit pat[4];
    bit exp_rdy;

    tbl[0] = '{32'h0800_1234, 16'h0010, 1'b1, 3'd0, R0};
    tbl[1] = '{32'h86DD_0000, 16'h0011, 1'b1, 3'd3, R3};
    tbl[2] = '{32'h86DD_1234, 16'h0012, 1'b1, 3'd1, R1};
    tbl[3] = '{32'h0801_0000, 16'h0013, 1'b1, 3'd0, R0};
    tbl[4] = '{32'h0900_1234, 16'h0014, 1'b1, 3'd1, R1};
    tbl[5] = '{32'h0000_1235, 16'h0015, 1'b1, 3'd3, R3};
    pat[0] = 1'b1;
    pat[1] = 1'b0;
    pat[2] = 1'b0;
    pat[3] = 1'b1;

    i_rst = 1'b1;
    i_rule_wren = 1'b0;
    i_rule_waddr = '0;
    i_rule_wdata = '0;
    i_rd_en = 1'b0;
    i_rd_addr = '0;
    i_rd_sel = 1'b0;
    lk.i_valid = 1'b0;
    lk.i_type = '0;
    lk.i_meta = '0;
    lk.i_ready = 1'b1;

    // reset state
    repeat (3) tick();
    chk("rst_ready", 128'(lk.o_ready), 128'(0));
    chk("rst_valid", 128'(lk.o_valid), 128'(0));
    chk("rst_hit", 128'(lk.o_hit), 128'(0));
    chk("rst_idx", 128'(lk.o_rule_idx), 128'(0));
    chk("rst_res", 128'(lk.o_result), 128'(0));
    chk("rst_meta", 128'(lk.o_meta), 128'(0));
    chk("rst_rdv", 128'(o_rd_valid), 128'(0));
    chk("rst_rdd", 128'(o_rd_data), 128'(0));
    i_rst = 1'b0;
    #1;
    chk("post_rst_ready", 128'(lk.o_ready), 128'(1));

    // empty table: misses with meta passed through
    do_lookup("miss0", 32'h0800_1234, 16'hBEEF, 1'b0, 3'd0, 48'd0, 1'b0, '0);
    do_lookup("miss1", 32'hFFFF_FFFF, 16'h1234, 1'b0, 3'd0, 48'd0, 1'b0, '0);

    wr_rule(3'd0, mk_rule(1'b1, 32'hFF00_0000, 32'h0800_0000, R0));
    wr_rule(3'd1, mk_rule(1'b1, 32'h0000_FFFF, 32'h0000_1234, R1));
    wr_rule(3'd3, mk_rule(1'b1, 32'h0000_0000, 32'h0000_0000, R3));

    for (int i = 0; i < 6; i++) begin
      do_lookup($sformatf("vec%0d", i), tbl[i].typ, tbl[i].meta,
                tbl[i].hit, tbl[i].idx, tbl[i].res, 1'b0, '0);
    end

    do_read(3'd1, 1'b0, rd);
    chk("rd_rule1", 128'(rd),
        128'(mk_rule(1'b1, 32'h0000_FFFF, 32'h0000_1234, R1)));

    // back-to-back with stalls: order, stability, o_ready
    sent = 0;
    got = 0;
    hold = 1'b0;
    held = '0;
    for (int cyc = 0; cyc < 64; cyc++) begin
      lk.i_ready = pat[cyc % 4];
      lk.i_valid = (sent < 8);
      lk.i_meta = 16'(sent);
      lk.i_type = 32'h0800_0000 | 32'(sent);
      #1;
      exp_rdy = !((sent - got) == 2 && !lk.i_ready);
      chk("b2b_ready", 128'(lk.o_ready), 128'(exp_rdy));
      if (hold) begin
        chk("hold_valid", 128'(lk.o_valid), 128'(1));
        chk("hold_meta", 128'(lk.o_meta), 128'(held));
        chk("hold_res", 128'(lk.o_result), 128'(R0));
      end
      hold = 1'b0;
      if (lk.o_valid) begin
        chk("b2b_meta", 128'(lk.o_meta), 128'(got));
        chk("b2b_idx", 128'(lk.o_rule_idx), 128'(0));
        if (lk.i_ready) begin
          got++;
        end else begin
          hold = 1'b1;
          held = 16'(got);
        end
      end
      if (lk.i_valid && lk.o_ready) sent++;
      if (got == 8) break;
      tick();
    end
    chk("b2b_count", 128'(got), 128'(8));
    tick();
    lk.i_valid = 1'b0;
    lk.i_ready = 1'b1;
    repeat (3) tick();

    // counter saturation, clear-on-read, coincident hit
    wr_rule(3'd0, mk_rule(1'b1, 32'hFF00_0000, 32'h0800_0000, R0));
    lk.i_type = 32'h0800_0000;
    lk.i_valid = 1'b1;
    repeat (20) tick();
    lk.i_valid = 1'b0;
    repeat (3) tick();
    do_read(3'd0, 1'b1, rd);
    chk("cnt_sat", 128'(rd), 128'(15));
    do_read(3'd0, 1'b1, rd);
    chk("cnt_clr", 128'(rd), 128'(0));
    lk.i_valid = 1'b1;
    i_rd_en = 1'b1;
    i_rd_addr = 3'd0;
    i_rd_sel = 1'b1;
    tick();
    lk.i_valid = 1'b0;
    i_rd_en = 1'b0;
    chk("coinc_rd", 128'(o_rd_data), 128'(0));
    repeat (2) tick();
    do_read(3'd0, 1'b1, rd);
    chk("coinc_cnt", 128'(rd), 128'(1));

    // disable rule0 in the same cycle as a matching accept
    do_lookup("wr_same", 32'h0800_0000, 16'h00A0, 1'b1, 3'd0, R0, 1'b1,
              mk_rule(1'b0, 32'hFF00_0000, 32'h0800_0000, R0));
    do_lookup("wr_next", 32'h0800_0000, 16'h00A1, 1'b1, 3'd3, R3, 1'b0, '0);
    do_read(3'd0, 1'b1, rd);
    chk("wr_cnt0", 128'(rd), 128'(0));

    // reset with two lookups in flight
    wr_rule(3'd0, mk_rule(1'b1, 32'hFF00_0000, 32'h0800_0000, R0));
    lk.i_ready = 1'b0;
    lk.i_valid = 1'b1;
    lk.i_meta = 16'h00AA;
    tick();
    lk.i_meta = 16'h00BB;
    tick();
    lk.i_valid = 1'b0;
    chk("pre_rst_valid", 128'(lk.o_valid), 128'(1));
    i_rst = 1'b1;
    tick();
    i_rst = 1'b0;
    lk.i_ready = 1'b1;
    for (int c = 0; c < 5; c++) begin
      chk("flush_valid", 128'(lk.o_valid), 128'(0));
      tick();
    end
    for (int r = 0; r < 4; r++) begin
      do_read(3'(r), 1'b1, rd);
      chk($sformatf("flush_cnt%0d", r), 128'(rd), 128'(0));
    end
    do_read(3'd0, 1'b0, rd);
    chk("flush_rule0_v", 128'(rd[RWD-1]), 128'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/lookup_type_pipe.md
Name: lookup_type_pipe

Overview:
- Parametrised, pipelined successor to the parser's type-lookup stage.
- Takes the extracted type fields of a packet under a valid/ready handshake and matches them against a masked rule table. The lowest-index hitting rule wins.
- Returns that rule's key-offset result, its index and a hit flag, together with pass-through metadata, to the key-extraction stage.
- Adds address-based rule writes, rule read-back, per-rule saturating hit counters and full backpressure.

Parameters:
- TYPE_NUM, 4, number of type fields per lookup
- TYPE_WIDTH, 8, bits per type field
- KEY_FIELD_NUM, 8, number of key-offset fields in a result
- KEY_OFFSET_WIDTH, 6, bits per key offset
- RULE_NUM, 8, rule table depth (>=2)
- RULE_AW, $clog2(RULE_NUM), rule address width
- META_WIDTH, 16, pass-through metadata width
- CNT_WIDTH, 32, hit counter width
- CLR_ON_READ, 1, 1 = counter read clears the counter
- RULE_WIDTH, 1+2*TYPE_NUM*TYPE_WIDTH+KEY_FIELD_NUM*KEY_OFFSET_WIDTH, rule layout {valid, mask, value, result}, MSB first

Ports:
- i_clk  in  1  clock
- i_rst  in  1  synchronous active-high reset
- i_valid  in  1  lookup request valid
- o_ready  out  1  lookup request ready
- i_type  in  [TYPE_NUM-1:0][TYPE_WIDTH-1:0]  type fields
- i_meta  in  META_WIDTH  metadata, returned unchanged
- o_valid  out  1  result valid
- i_ready  in  1  downstream ready
- o_hit  out  1  some rule matched
- o_rule_idx  out  RULE_AW  winning rule index
- o_result  out  [KEY_FIELD_NUM-1:0][KEY_OFFSET_WIDTH-1:0]  key offsets
- o_meta  out  META_WIDTH  metadata of this result
- i_rule_wren  in  1  rule write strobe
- i_rule_waddr  in  RULE_AW  rule write address
- i_rule_wdata  in  RULE_WIDTH  rule write data
- i_rd_en  in  1  read strobe
- i_rd_addr  in  RULE_AW  read address
- i_rd_sel  in  1  0 = rule, 1 = counter
- o_rd_valid  out  1  read data valid
- o_rd_data  out  RULE_WIDTH  read data (counter zero-extended)

Behaviour:

Reset (i_rst high at a clock edge):
- All rule valid bits, counters and pipeline valids cleared.
- Outputs o_valid, o_hit, o_rule_idx, o_result, o_meta, o_rd_valid and o_rd_data are all 0.
- o_ready is 0 during reset and 1 in the first cycle after it.
- Reset mid-operation drops any in-flight lookups; no output is produced for them.

Match:
- rule i hits iff valid_i and ((i_type & mask_i) == value_i), with i_type flattened so field k occupies bits [k*TYPE_WIDTH +: TYPE_WIDTH].
- Mask bit 0 means don't-care. A rule whose mask is all-zero matches everything.
- Priority: the lowest hitting index wins.
- Miss: o_hit=0, o_rule_idx=0, o_result=0.

Pipeline:
- Two register stages, S1 and S2 (output).
- An accept happens when i_valid and o_ready are both high. In that cycle, match, priority encode and result select are evaluated on the current table contents and registered into S1.
- S1 moves to S2 when S2 is empty or is being consumed.
- Latency is exactly 2 cycles from accept to o_valid when there is no stall.
- o_ready = !S1.valid | (!S2.valid | i_ready). This gives full throughput of one lookup per cycle.
- Outputs hold stable while o_valid=1 and i_ready=0.
- No loss, duplication or reordering under any i_ready pattern.

Rule write:
- Takes effect at the clock edge: r_rule[waddr] <= wdata, and the write clears counter[waddr].
- A write and an accept in the same cycle: the accept sees the old table. The next accept sees the new rule.
- Writing valid=0 disables the rule.

Hit counters:
- On accept with a hit, counter[winner] increments and saturates at 2^CNT_WIDTH-1.
- A rule write to the same index in the same cycle wins: the counter becomes 0.

Read:
- o_rd_valid and o_rd_data are registered one cycle after i_rd_en.
- The read returns the pre-edge value.
- If CLR_ON_READ=1 and i_rd_sel=1, the counter is cleared at the read edge. If an increment of the same counter coincides, the counter becomes 1; the increment is not lost.
- Reads are independent of the lookup handshake.

Test Plan:
- Reset, write rule0 {mask=FF00_0000, value=0800_0000, result=R0} and rule3 {mask=0, result=R3}. Lookup type 0x0800_1234 -> after 2 cycles, o_hit=1, idx=0, result=R0. Lookup 0x86DD_0000 -> idx=3, result=R3.
- With no valid rules, lookup -> o_valid=1, o_hit=0, idx=0, result=0, o_meta equal to the input meta.
- 8 back-to-back lookups with meta 0..7 while i_ready toggles 1,0,0,1,... -> all 8 returned in order and held stable during stalls; o_ready drops only when both stages are full.
- CNT_WIDTH=4: 20 hits on rule0 -> counter read = 15 (saturated). Read again with CLR_ON_READ=1 -> 0. A read coinciding with a hit -> counter becomes 1.
- In the same cycle, overwrite rule0 with valid=0 and accept a lookup that matches rule0 -> this lookup hits idx 0. The next lookup -> idx 3. Counter0 = 0.
- Assert i_rst with 2 lookups in flight -> no o_valid afterwards, counters=0, read-back of rule0 shows valid=0.
